// File: rtl/gate_bist_pkg.sv
// Shared widths, tap constants and FSM encoding for the gate-model BIST controller.
package gate_bist_pkg;

  localparam int STIM_W = 20;
  localparam int RESP_W = 10;
  localparam int SIG_W  = 16;

  // Feedback taps: LFSR bits 19,16; MISR bits 15,13,12,10
  localparam logic [STIM_W-1:0] LFSR_TAPS = 20'h90000;
  localparam logic [SIG_W-1:0]  MISR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE_W,
    CAPTURE,
    COMPARE,
    DONE
  } state_t;

  function automatic logic [STIM_W-1:0] lfsr_next(input logic [STIM_W-1:0] s);
    return {s[STIM_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bist_misr.sv
// 16-bit multiple-input signature register with seed load and a 10-bit parallel input.
module bist_misr
  import gate_bist_pkg::*;
#(
  parameter logic [SIG_W-1:0] SEED = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [RESP_W-1:0] din,
  output logic [SIG_W-1:0]  sig
);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], ^(sig & MISR_TAPS)} ^ {{(SIG_W-RESP_W){1'b0}}, din};
    end
  end

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST controller: LFSR stimulus into a gate model, MISR compaction, golden compare.
// Optional GATE_BIST_SIG_OUT_EN exposes the live signature (sig_out) and pattern index (pat_idx).
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int               PAT_CNT   = 1024,
  parameter int               SETTLE    = 0,
  parameter logic [19:0]      LFSR_SEED = 20'h00001,
  parameter logic [15:0]      MISR_SEED = 16'h0000,
  localparam int              CNT_W     = $clog2(PAT_CNT + 1),
  localparam int              SET_W     = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SIG_W-1:0]   golden,
  output logic [STIM_W-1:0]  stim,
  input  logic [RESP_W-1:0]  resp,
  output logic               busy,
  output logic               done,
  output logic               pass
`ifdef GATE_BIST_SIG_OUT_EN
  ,
  output logic [SIG_W-1:0]   sig_out,
  output logic [CNT_W-1:0]   pat_idx
`endif
);

  state_t             state;
  logic [CNT_W-1:0]   pat_cnt;
  logic [SET_W-1:0]   settle_cnt;
  logic [SIG_W-1:0]   sig;

  bist_misr #(.SEED(MISR_SEED)) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (state == LOAD),
    .en   (state == CAPTURE),
    .din  (resp),
    .sig  (sig)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      stim       <= LFSR_SEED;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      pat_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          stim       <= LFSR_SEED;
          pat_cnt    <= '0;
          settle_cnt <= '0;
          pass       <= 1'b0;
          state      <= (SETTLE > 0) ? SETTLE_W : CAPTURE;
        end
        SETTLE_W: begin
          if (settle_cnt == SET_W'(SETTLE - 1)) begin
            settle_cnt <= '0;
            state      <= CAPTURE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        CAPTURE: begin
          stim    <= lfsr_next(stim);
          pat_cnt <= pat_cnt + 1'b1;
          // pat_cnt still holds the pre-increment value here
          if (pat_cnt == CNT_W'(PAT_CNT - 1)) begin
            state <= COMPARE;
          end else begin
            state <= (SETTLE > 0) ? SETTLE_W : CAPTURE;
          end
        end
        COMPARE: begin
          pass  <= (sig == golden);
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef GATE_BIST_SIG_OUT_EN
  assign sig_out = sig;
  assign pat_idx = pat_cnt;
`endif

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed scoreboard bench for gate_bist_ctrl across four parameterisations.
module tb_gate_bist_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  logic [3:0]  start_v = '0;
  logic [15:0] golden_v [4];
  logic [19:0] stim_v [4];
  logic [3:0]  busy_v, done_v, pass_v;
  logic [9:0]  resp_a = '0, resp_b = '0, resp_c = '0;
  logic [9:0]  resp_d;

  // Stand-in combinational gate model driven by the BIST stimulus
  function automatic logic [9:0] gate_model(input logic [19:0] s);
    return s[19:10] ^ (s[9:0] & {s[4:0], s[19:15]}) ^ {9'b0, &s[3:0]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [9:0] r);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ {6'b0, r};
  endfunction

  function automatic logic [19:0] lfsr_step(input logic [19:0] l);
    return {l[18:0], l[19] ^ l[16]};
  endfunction

  assign resp_d = gate_model(stim_v[3]);

`ifdef GATE_BIST_SIG_OUT_EN
  logic [15:0] so_v [4];
  logic [2:0]  pi_a;
  logic [0:0]  pi_b;
  logic [1:0]  pi_c;
  logic [10:0] pi_d;
`endif

  gate_bist_ctrl #(.PAT_CNT(4), .SETTLE(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .golden(golden_v[0]), .stim(stim_v[0]),
    .resp(resp_a), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0])
`ifdef GATE_BIST_SIG_OUT_EN
    , .sig_out(so_v[0]), .pat_idx(pi_a)
`endif
  );

  gate_bist_ctrl #(.PAT_CNT(1), .SETTLE(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .golden(golden_v[1]), .stim(stim_v[1]),
    .resp(resp_b), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1])
`ifdef GATE_BIST_SIG_OUT_EN
    , .sig_out(so_v[1]), .pat_idx(pi_b)
`endif
  );

  gate_bist_ctrl #(.PAT_CNT(2), .SETTLE(3)) dut_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .golden(golden_v[2]), .stim(stim_v[2]),
    .resp(resp_c), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2])
`ifdef GATE_BIST_SIG_OUT_EN
    , .sig_out(so_v[2]), .pat_idx(pi_c)
`endif
  );

  gate_bist_ctrl dut_d (
    .clk(clk), .rst(rst), .start(start_v[3]), .golden(golden_v[3]), .stim(stim_v[3]),
    .resp(resp_d), .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3])
`ifdef GATE_BIST_SIG_OUT_EN
    , .sig_out(so_v[3]), .pat_idx(pi_d)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: observed 0x%0h with no expected entry", obs);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  // Raises start for one edge; returns at the negedge of the first cycle after it (cycle 1)
  task automatic start_run(input int idx);
    start_v[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[idx] = 1'b0;
  endtask

  // Waits for done; lat is the cycle (relative to the start edge) in which done is seen
  task automatic wait_done(input int idx, input int budget, output int lat);
    lat = 1;
    while (!done_v[idx] && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    if (!done_v[idx]) begin
      checks++;
      errors++;
      $display("FAIL timeout_dut%0d: observed no done within %0d cycles, required done", idx, budget);
    end
  endtask

  initial begin
    int lat;
    int dcnt;
    logic [15:0] ms;
    logic [19:0] ml;
    logic [15:0] gold;

    foreach (golden_v[i]) golden_v[i] = '0;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stim", stim_v[0], 20'h00001);
    chk("rst_busy", busy_v[0], 1'b0);
    chk("rst_done", done_v[0], 1'b0);
    chk("rst_pass", pass_v[0], 1'b0);
    chk("rst_stim_d", stim_v[3], 20'h00001);
    rst = 1'b0;
    @(negedge clk);

    // Zero response, PAT_CNT=4
    push("a_stim0", 20'h00001);
    push("a_stim1", 20'h00002);
    push("a_stim2", 20'h00004);
    push("a_stim3", 20'h00008);
    push("a_latency", 7);
    push("a_pass", 1);
    start_run(0);
    lat = 0;
    dcnt = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cyc >= 2 && cyc <= 5) pop_chk(stim_v[0]);
      if (cyc == 6) chk("a_busy_compare", busy_v[0], 1'b1);
      if (done_v[0]) begin
        dcnt++;
        if (lat == 0) lat = cyc;
        chk("a_busy_at_done", busy_v[0], 1'b0);
      end
      @(negedge clk);
    end
    pop_chk(lat);
    pop_chk(pass_v[0]);
    chk("a_done_pulses", dcnt, 1);
    $display("run a: latency=%0d pass=%0b", lat, pass_v[0]);

    // Single capture, PAT_CNT=1
    resp_b = 10'h001;
    golden_v[1] = 16'h0001;
    push("b1_latency", 4);
    push("b1_pass", 1);
    start_run(1);
    wait_done(1, 20, lat);
    pop_chk(lat);
    pop_chk(pass_v[1]);
    repeat (3) @(negedge clk);
    chk("b1_pass_held", pass_v[1], 1'b1);
    $display("run b1: latency=%0d pass=%0b", lat, pass_v[1]);

    golden_v[1] = 16'h0000;
    push("b2_latency", 4);
    push("b2_pass", 0);
    start_run(1);
    wait_done(1, 20, lat);
    pop_chk(lat);
    pop_chk(pass_v[1]);
    $display("run b2: latency=%0d pass=%0b", lat, pass_v[1]);

    // start coinciding with rst is ignored
    rst = 1'b1;
    start_v[1] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start_v[1] = 1'b0;
    @(negedge clk);
    chk("b_start_during_rst_busy", busy_v[1], 1'b0);

    // SETTLE=3, PAT_CNT=2, with a start pulse while busy
    for (int i = 0; i < 4; i++) push("c_stim_p0", 20'h00001);
    for (int i = 0; i < 4; i++) push("c_stim_p1", 20'h00002);
    push("c_stim_cmp", 20'h00004);
    push("c_stim_done", 20'h00004);
    push("c_latency", 11);
    push("c_pass", 1);
    start_run(2);
    lat = 0;
    dcnt = 0;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      start_v[2] = (cyc == 5);
      if (cyc >= 2 && cyc <= 11) pop_chk(stim_v[2]);
      if (done_v[2]) begin
        dcnt++;
        if (lat == 0) lat = cyc;
      end
      @(negedge clk);
    end
    start_v[2] = 1'b0;
    pop_chk(lat);
    pop_chk(pass_v[2]);
    chk("c_done_pulses", dcnt, 1);
    chk("c_idle_after", busy_v[2], 1'b0);
    $display("run c: latency=%0d pass=%0b", lat, pass_v[2]);

    // Reset mid-run at pattern 500
    start_run(3);
    for (int cyc = 1; cyc < 502; cyc++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("d_rst_busy", busy_v[3], 1'b0);
    chk("d_rst_done", done_v[3], 1'b0);
    chk("d_rst_stim", stim_v[3], 20'h00001);
    chk("d_rst_pass", pass_v[3], 1'b0);
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_v[3]) dcnt++;
      @(negedge clk);
    end
    chk("d_no_done_after_rst", dcnt, 0);
    $display("run d1: aborted at pattern 500");

    // Fresh full run against the reference signature
    ms = 16'h0000;
    ml = 20'h00001;
    for (int p = 0; p < 1024; p++) begin
      ms = misr_step(ms, gate_model(ml));
      ml = lfsr_step(ml);
    end
    gold = ms;
    golden_v[3] = gold;
    push("d_latency", 1027);
    push("d_pass", 1);
    start_run(3);
    ms = 16'h0000;
    ml = 20'h00001;
    lat = 0;
    for (int cyc = 1; cyc <= 1040 && lat == 0; cyc++) begin
`ifdef GATE_BIST_SIG_OUT_EN
      if (cyc >= 3 && cyc <= 1026) begin
        ms = misr_step(ms, gate_model(ml));
        ml = lfsr_step(ml);
        chk("d_sig_out", so_v[3], ms);
        chk("d_pat_idx", pi_d, cyc - 2);
      end
`endif
      if (done_v[3]) lat = cyc;
      else @(negedge clk);
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_dut3: observed no done within 1040 cycles, required done");
    end
    pop_chk(lat);
    pop_chk(pass_v[3]);
    $display("run d2: latency=%0d pass=%0b golden=0x%04h", lat, pass_v[3], gold);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
